// File: rtl/ib_lut_page_loader.sv
// ib_lut_page_loader
//
// Write-side sequencer for an IB LUT distributed-RAM bank. It accepts packed
// LUT words over a valid/ready handshake and writes them into the memory one
// page per cycle, starting at page 0, until PAGE_NUM pages are filled.
//
// The optional read-back check is compiled in with the macro
// IB_LUT_LOADER_VERIFY_EN. When it is enabled, the loader sweeps the memory's
// asynchronous read port after the last write. It compares an 8-bit modular
// sum of the data read back against the sum of the data written, and latches
// any mismatch in verify_err_o.
//
// Ports
//   write_clk      single clock for all logic
//   rstn           asynchronous active-low reset
//   start_i        load request, sampled only while idle
//   in_data_i      PACK_NUM packed entries, entry 0 in the low bits, written first
//   in_valid_i     upstream word valid
//   in_ready_o     loader can accept a word (decoded from state)
//   write_addr_o   page address to memory (registered)
//   write_data_o   page data to memory (registered)
//   we_o           memory write enable (registered)
//   busy_o         load in progress, through the done pulse
//   done_o         one-cycle pulse at the end of a load
//   read_addr_o    read-back address (0 when verify is not compiled in)
//   read_page_i    asynchronous read data from memory
//   verify_err_o   sticky checksum mismatch, cleared by the next start_i
module ib_lut_page_loader #(
  parameter int QUAN_SIZE     = 3,
  parameter int PAGE_NUM      = 32,
  parameter int ADDR_BITWIDTH = 5,
  parameter int PACK_NUM      = 4
) (
  input  logic                          write_clk,
  input  logic                          rstn,
  input  logic                          start_i,
  input  logic [PACK_NUM*QUAN_SIZE-1:0] in_data_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  output logic [ADDR_BITWIDTH-1:0]      write_addr_o,
  output logic [QUAN_SIZE-1:0]          write_data_o,
  output logic                          we_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [ADDR_BITWIDTH-1:0]      read_addr_o,
  input  logic [QUAN_SIZE-1:0]          read_page_i,
  output logic                          verify_err_o
);

  localparam int IDX_W = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
  localparam logic [ADDR_BITWIDTH-1:0] LAST_PAGE = ADDR_BITWIDTH'(PAGE_NUM - 1);
  localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(PACK_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_VERIFY,
    S_DONE
  } state_t;

  state_t                        state;
  state_t                        state_next;
  logic [ADDR_BITWIDTH-1:0]      page_cnt;
  logic [IDX_W-1:0]              entry_idx;
  logic [PACK_NUM*QUAN_SIZE-1:0] hold_word;
  logic [QUAN_SIZE-1:0]          cur_entry;
  logic                          last_page;
  logic                          last_entry;

`ifdef IB_LUT_LOADER_VERIFY_EN
  logic [7:0] wr_sum;
  logic [7:0] rd_sum;
  logic       cmp_pending;

  // 8-bit modular running sum with the entry zero-extended.
  function automatic logic [7:0] sum8(input logic [7:0] acc,
                                      input logic [QUAN_SIZE-1:0] entry);
    return acc + 8'(entry);
  endfunction
`endif

  assign last_page  = (page_cnt == LAST_PAGE);
  assign last_entry = (entry_idx == LAST_IDX);
  assign cur_entry  = hold_word[int'(entry_idx)*QUAN_SIZE +: QUAN_SIZE];
  assign in_ready_o = (state == S_FETCH);

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start_i) state_next = S_FETCH;
      S_FETCH: if (in_valid_i) state_next = S_WRITE;
      S_WRITE: begin
        // The final page wins over the word boundary, so any entries left in
        // the final word are dropped.
        if (last_page) begin
`ifdef IB_LUT_LOADER_VERIFY_EN
          state_next = S_VERIFY;
`else
          state_next = S_DONE;
`endif
        end else if (last_entry) begin
          state_next = S_FETCH;
        end
      end
`ifdef IB_LUT_LOADER_VERIFY_EN
      S_VERIFY: if (cmp_pending) state_next = S_DONE;
`endif
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_next;
  end

  // Holding register for the accepted word. It carries only data, so it has
  // no reset.
  always_ff @(posedge write_clk) begin
    if (state == S_FETCH && in_valid_i) hold_word <= in_data_i;
  end

  // Write sequencing and registered status outputs.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      page_cnt     <= '0;
      entry_idx    <= '0;
      we_o         <= 1'b0;
      write_addr_o <= '0;
      write_data_o <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      we_o   <= 1'b0;
      done_o <= (state == S_DONE);
      // busy_o stays high through the done pulse and drops together with it.
      busy_o <= (state_next != S_IDLE) || (state == S_DONE);
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            page_cnt  <= '0;
            entry_idx <= '0;
          end
        end
        S_FETCH: entry_idx <= '0;
        S_WRITE: begin
          we_o         <= 1'b1;
          write_addr_o <= page_cnt;
          write_data_o <= cur_entry;
          page_cnt     <= page_cnt + ADDR_BITWIDTH'(1);
          entry_idx    <= entry_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef IB_LUT_LOADER_VERIFY_EN
  // Read-back sweep. read_addr_o holds address k for one cycle, and the
  // asynchronous read data for it is summed at the closing edge. One extra
  // cycle (cmp_pending) compares the two finished sums.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      wr_sum       <= '0;
      rd_sum       <= '0;
      cmp_pending  <= 1'b0;
      read_addr_o  <= '0;
      verify_err_o <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            wr_sum       <= '0;
            rd_sum       <= '0;
            cmp_pending  <= 1'b0;
            read_addr_o  <= '0;
            verify_err_o <= 1'b0;
          end
        end
        S_WRITE: wr_sum <= sum8(wr_sum, cur_entry);
        S_VERIFY: begin
          if (cmp_pending) begin
            verify_err_o <= verify_err_o | (rd_sum != wr_sum);
            cmp_pending  <= 1'b0;
          end else begin
            rd_sum <= sum8(rd_sum, read_page_i);
            if (read_addr_o == LAST_PAGE) begin
              read_addr_o <= '0;
              cmp_pending <= 1'b1;
            end else begin
              read_addr_o <= read_addr_o + ADDR_BITWIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
`else
  logic unused_read_page;
  assign unused_read_page = ^read_page_i;
  assign read_addr_o      = '0;
  assign verify_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_ib_lut_page_loader.sv
module tb_ib_lut_page_loader;

  localparam int QS = 3;
  localparam int PK = 4;
  localparam int AW = 5;
  localparam int DW = PK * QS;
`ifdef IB_LUT_LOADER_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam bit VERIFY_ON = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] a;
    logic [QS-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start    [2];
  logic [DW-1:0] in_data  [2];
  logic          in_valid [2];
  logic          in_ready [2];
  logic [AW-1:0] waddr    [2];
  logic [QS-1:0] wdata    [2];
  logic          we       [2];
  logic          busy     [2];
  logic          done     [2];
  logic [AW-1:0] raddr    [2];
  logic [QS-1:0] rpage    [2];
  logic          verr     [2];

  // Memory model of the two LUT banks, preset to a sentinel value.
  logic [QS-1:0] mem     [2][32] = '{default: '{default: 3'd6}};
  logic [QS-1:0] exp_mem [2][32] = '{default: '{default: 3'd6}};
  bit            corrupt = 1'b0;

  wr_t exp_q0[$];
  wr_t exp_q1[$];
  int  ref_page    [2];
  int  wr_cnt      [2];
  int  done_cnt    [2];
  int  last_we_cyc [2];
  int  done_cyc    [2];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ib_lut_page_loader #(.QUAN_SIZE(QS), .PAGE_NUM(32), .ADDR_BITWIDTH(AW), .PACK_NUM(PK)) dut0 (
    .write_clk(clk), .rstn(rstn), .start_i(start[0]), .in_data_i(in_data[0]),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .write_addr_o(waddr[0]),
    .write_data_o(wdata[0]), .we_o(we[0]), .busy_o(busy[0]), .done_o(done[0]),
    .read_addr_o(raddr[0]), .read_page_i(rpage[0]), .verify_err_o(verr[0]));

  ib_lut_page_loader #(.QUAN_SIZE(QS), .PAGE_NUM(30), .ADDR_BITWIDTH(AW), .PACK_NUM(PK)) dut1 (
    .write_clk(clk), .rstn(rstn), .start_i(start[1]), .in_data_i(in_data[1]),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .write_addr_o(waddr[1]),
    .write_data_o(wdata[1]), .we_o(we[1]), .busy_o(busy[1]), .done_o(done[1]),
    .read_addr_o(raddr[1]), .read_page_i(rpage[1]), .verify_err_o(verr[1]));

  // Synchronous write port, asynchronous read port. Unit 0 can flip a bit of
  // page 17 on read to emulate a corrupted cell.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++)
      if (we[u] === 1'b1) mem[u][waddr[u]] <= wdata[u];
  end

  always_comb begin
    rpage[0] = mem[0][raddr[0]];
    if (corrupt && raddr[0] == 5'd17) rpage[0] = mem[0][raddr[0]] ^ 3'b001;
    rpage[1] = mem[1][raddr[1]];
  end

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic int pages_of(int u);
    return (u == 0) ? 32 : 30;
  endfunction

  // Reference model: the loader writes entries in order to consecutive pages
  // from 0 and stops at the page count, discarding the remaining entries.
  function automatic void push_word(int u, logic [DW-1:0] w);
    wr_t e;
    for (int k = 0; k < PK; k++) begin
      if (ref_page[u] < pages_of(u)) begin
        e.a = AW'(ref_page[u]);
        e.d = w[k*QS +: QS];
        exp_mem[u][ref_page[u]] = e.d;
        if (u == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        ref_page[u]++;
      end
    end
  endfunction

  // Scoreboard monitor: every write the DUT presents is popped and compared.
  always @(negedge clk) begin
    wr_t e;
    for (int u = 0; u < 2; u++) begin
      if (we[u] === 1'b1) begin
        wr_cnt[u]++;
        last_we_cyc[u] = cyc;
        if ((u == 0 && exp_q0.size() == 0) || (u == 1 && exp_q1.size() == 0)) begin
          check("unexpected_write", 1, 0);
        end else begin
          if (u == 0) e = exp_q0.pop_front();
          else        e = exp_q1.pop_front();
          check("write_addr", int'(waddr[u]), int'(e.a));
          check("write_data", int'(wdata[u]), int'(e.d));
        end
      end
      if (done[u] === 1'b1) begin
        done_cnt[u]++;
        done_cyc[u] = cyc;
      end
    end
  end

  function automatic void check_zero_outputs(int u);
    check("rst_in_ready", in_ready[u], 0);
    check("rst_we", we[u], 0);
    check("rst_write_addr", int'(waddr[u]), 0);
    check("rst_write_data", int'(wdata[u]), 0);
    check("rst_busy", busy[u], 0);
    check("rst_done", done[u], 0);
    check("rst_read_addr", int'(raddr[u]), 0);
    check("rst_verify_err", verr[u], 0);
  endfunction

  // One complete load. pat selects the (page mod 8) pattern instead of random
  // data; stall_w holds valid low for 5 FETCH cycles before that word; poke
  // pulses start_i while the second word is being written.
  task automatic do_load(input int u, input bit pat, input int stall_w, input bit poke);
    int np, nw, t0, guard, exp_span;
    logic [DW-1:0] w;
    bit ok;
    np = pages_of(u);
    nw = (np + PK - 1) / PK;
    ref_page[u] = 0;
    wr_cnt[u] = 0;
    done_cnt[u] = 0;
    ok = 1'b1;
    @(negedge clk);
    start[u] = 1'b1;
    @(negedge clk);
    start[u] = 1'b0;
    check("fetch_ready", in_ready[u], 1);
    check("fetch_busy", busy[u], 1);
    check("start_clears_err", verr[u], 0);
    t0 = cyc;
    for (int wi = 0; wi < nw && ok; wi++) begin
      for (int k = 0; k < PK; k++)
        w[k*QS +: QS] = pat ? QS'((wi * PK + k) % 8) : QS'($urandom_range(0, 7));
      if (wi == stall_w) begin
        in_valid[u] = 1'b0;
        guard = 0;
        while (!in_ready[u] && guard < 50) begin
          @(negedge clk);
          guard++;
        end
        for (int s = 0; s < 5; s++) begin
          check("stall_ready", in_ready[u], 1);
          if (s > 0) check("stall_no_we", we[u], 0);
          @(negedge clk);
        end
      end
      in_data[u] = w;
      in_valid[u] = 1'b1;
      guard = 0;
      while (!in_ready[u] && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready[u]) begin
        check("accept_timeout", 0, 1);
        ok = 1'b0;
      end else begin
        push_word(u, w);
        @(negedge clk);
        if (poke && wi == 1) begin
          start[u] = 1'b1;
          @(negedge clk);
          start[u] = 1'b0;
        end
      end
    end
    in_valid[u] = 1'b0;
    guard = 0;
    while (!(done_cnt[u] > 0 && !busy[u]) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("done_seen", int'(done_cnt[u] > 0), 1);
    repeat (5) @(negedge clk);
    check("done_single_pulse", done_cnt[u], 1);
    check("busy_low_after", busy[u], 0);
    check("write_count", wr_cnt[u], np);
    check("queue_drained", (u == 0) ? exp_q0.size() : exp_q1.size(), 0);
    check("done_latency", done_cyc[u] - last_we_cyc[u], VERIFY_ON ? np + 2 : 1);
    if (stall_w < 0 && !poke) begin
      exp_span = np + nw;
      check("load_span", last_we_cyc[u] - t0, exp_span);
    end
    for (int p = 0; p < 32; p++) check("mem_content", int'(mem[u][p]), int'(exp_mem[u][p]));
    check("verify_err", verr[u], int'(VERIFY_ON && corrupt && u == 0));
    check("read_addr_idle", int'(raddr[u]), 0);
  endtask

  initial begin
    int guard;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0;
      in_valid[u] = 1'b0;
      in_data[u] = '0;
      wr_cnt[u] = 0;
      done_cnt[u] = 0;
      ref_page[u] = 0;
      last_we_cyc[u] = 0;
      done_cyc[u] = 0;
    end
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs(0);
    check_zero_outputs(1);
    rstn = 1'b1;

    // Pattern load: page p holds p mod 8, continuous valid.
    do_load(0, 1'b1, -1, 1'b0);
    for (int p = 0; p < 32; p++) check("pattern_page", int'(mem[0][p]), p % 8);

    // Upstream stall before word 3.
    do_load(0, 1'b0, 3, 1'b0);

    // Reset while page 10 is being written, then a clean reload.
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    ref_page[0] = 0;
    guard = 0;
    while (!(we[0] === 1'b1 && waddr[0] == 5'd10) && guard < 100) begin
      if (in_ready[0]) begin
        in_data[0] = DW'($urandom);
        in_valid[0] = 1'b1;
        push_word(0, in_data[0]);
      end
      @(negedge clk);
      guard++;
    end
    check("reached_page10", int'(we[0] === 1'b1 && waddr[0] == 5'd10), 1);
    #2;
    rstn = 1'b0;
    #1;
    check_zero_outputs(0);
    exp_q0.delete();
    in_valid[0] = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    do_load(0, 1'b0, -1, 1'b0);

    // 30-page bank: pages 30/31 keep their sentinel.
    do_load(1, 1'b0, -1, 1'b0);
    check("page30_untouched", int'(mem[1][30]), 6);
    check("page31_untouched", int'(mem[1][31]), 6);

    // start_i during WRITE is ignored, followed by a clean reload.
    do_load(0, 1'b0, -1, 1'b1);
    do_load(0, 1'b0, -1, 1'b0);

    // Corrupted read-back (only meaningful with verify compiled in).
    corrupt = 1'b1;
    do_load(0, 1'b0, -1, 1'b0);
    repeat (4) @(negedge clk);
    check("verify_err_held", verr[0], int'(VERIFY_ON));
    corrupt = 1'b0;
    do_load(0, 1'b0, -1, 1'b0);

    // Randomized stall placement on both banks.
    for (int r = 0; r < 3; r++) begin
      do_load(0, 1'b0, $urandom_range(0, 7), 1'b0);
      do_load(1, 1'b0, $urandom_range(0, 7), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ib_lut_page_loader.md
# ib_lut_page_loader

Write-side sequencer for the IB LUT cell memories: it accepts packed LUT entries from an upstream stream over a valid/ready handshake, then drives the memory's synchronous write port one 3-bit page per cycle until all PAGE_NUM pages are filled. It sits between the LUT configuration path and each distributed-RAM LUT bank. It reports busy/done status and, optionally, a read-back checksum result through the memory's asynchronous read port.

## Interface
- QUAN_SIZE, 3, bit width of one LUT page entry
- PAGE_NUM, 32, number of pages to fill per load
- ADDR_BITWIDTH, 5, page address width; must satisfy 2^ADDR_BITWIDTH >= PAGE_NUM
- PACK_NUM, 4, entries per input word; entry k occupies bits [k*QUAN_SIZE +: QUAN_SIZE], entry 0 is written first
- write_clk  in  1  single clock for all logic
- rstn  in  1  asynchronous active-low reset
- start_i  in  1  load request; sampled only in IDLE
- in_data_i  in  PACK_NUM*QUAN_SIZE  packed LUT entries
- in_valid_i  in  1  upstream word valid
- in_ready_o  out  1  loader can accept a word
- write_addr_o  out  ADDR_BITWIDTH  page address to memory
- write_data_o  out  QUAN_SIZE  page data to memory
- we_o  out  1  memory write enable
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse at end of load (after verify, when compiled in)
- read_addr_o  out  ADDR_BITWIDTH  read-back address to memory
- read_page_i  in  QUAN_SIZE  asynchronous read data from memory
- verify_err_o  out  1  sticky read-back checksum mismatch

## Operation
- States: IDLE, FETCH, WRITE, VERIFY, DONE.
- IDLE: start_i=1 -> FETCH; page counter and entry index cleared, verify_err_o cleared, write checksum cleared.
- FETCH: in_ready_o=1. On in_valid_i & in_ready_o, capture in_data_i into a holding register -> WRITE. in_valid_i low: wait indefinitely.
- WRITE: one entry per cycle; we_o=1, write_addr_o=page counter, write_data_o=entry[index]; page counter and index increment; write checksum += entry (8-bit modular sum, zero-extended).
  - index reaching PACK_NUM-1 with pages remaining -> FETCH.
  - Writing page PAGE_NUM-1 -> VERIFY (macro on) or DONE (macro off). Unused entries of the final word are discarded.
- VERIFY: read_addr_o sweeps 0..PAGE_NUM-1, one per cycle; read_page_i summed same cycle into read checksum. After the last address, mismatch sets verify_err_o -> DONE.
- DONE: done_o=1 for one cycle -> IDLE.
- start_i outside IDLE is ignored; no queueing.
- Reset mid-load: all state returns to IDLE immediately; partially written memory content is not rolled back.

## Timing
- Reset values: in_ready_o=0, we_o=0, write_addr_o=0, write_data_o=0, busy_o=0, done_o=0, read_addr_o=0, verify_err_o=0.
- All outputs registered except in_ready_o (decoded from state).
- start_i sampled at edge N -> FETCH, in_ready_o high from cycle N+1.
- Word accepted at edge M -> first write (we_o=1) in cycle M+1; memory captures it at edge M+2.
- One FETCH cycle minimum between words: a full load with continuous valid takes PAGE_NUM + ceil(PAGE_NUM/PACK_NUM) cycles from FETCH entry to last write (defaults: 40).
- Verify adds PAGE_NUM cycles plus one compare cycle; read_addr_o changes on write_clk edges, read_page_i sampled at the following edge.
- done_o asserts the cycle after the last write (macro off) or after the compare (macro on); busy_o falls with done_o's deassertion.

## Configuration
- IB_LUT_LOADER_VERIFY_EN defined: VERIFY state, checksums, read_addr_o sweep and verify_err_o are implemented.
- Undefined: WRITE goes directly to DONE; read_addr_o and verify_err_o tied 0; read_page_i ignored. Ports remain present in both builds.

## Test plan
- Reset mid-WRITE (rstn low at page 10) -> all outputs 0 next sample, busy_o=0; new start_i performs a full load from page 0.
- Defaults, 8 back-to-back words with entries 0..31 mod 8 -> pages 0..31 hold addr[2:0]; 40 cycles from FETCH to last write; done_o single pulse.
- in_valid_i held low 5 cycles before word 3 -> in_ready_o stays high, we_o low during stall, no page skipped or duplicated.
- PAGE_NUM=30, PACK_NUM=4 -> exactly 30 writes; final word's entries 2,3 never written; page 30/31 memory contents untouched.
- start_i pulsed during WRITE -> ignored; single done_o; second start after DONE performs a clean reload.
- Macro on, bench memory model corrupts page 17 -> verify_err_o=1 after compare, held until next start_i; clean memory -> verify_err_o=0.
